// File: rtl/ula_seq.sv
// ula_seq -- sequential arithmetic/logic unit with an optional iterative divider.
//
// Accepts one operation per request: Seletor, A and B are captured on the edge
// where start is seen in IDLE. Single-cycle operations register their result
// one edge later; a divide by a non-zero B runs a restoring divider producing
// one quotient bit per cycle (MSB first) for WIDTH cycles.
//
// Build option: define ULA_DIV_EN to include the iterative divider and the DIV
// state. Without it, operation 0011 completes in one cycle with S=0, zero=1,
// err=1.
//
// Ports:
//   clock    : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : operation request, sampled only in IDLE
//   Seletor  : 4-bit operation select, captured with start
//   A, B     : WIDTH-bit unsigned operands, captured with start
//   busy     : high while an accepted operation is in flight
//   done     : one-cycle pulse, S and flags valid
//   S        : 2*WIDTH-bit registered result, held until the next done
//   zero     : S is all zeros (updated with done)
//   carry    : carry (ADD) / borrow (SUB), 0 otherwise (updated with done)
//   err      : divide by zero, or divide requested without the divider

module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         Seletor,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] S,
  output logic               zero,
  output logic               carry,
  output logic               err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  // CALC is the single cycle between acceptance and the result edge; it is
  // where the captured operands are evaluated (or the divider is loaded).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
`ifdef ULA_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic               accept;
  logic [3:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] s_reg;
  logic               zero_reg, carry_reg, err_reg;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] alu_s;
  logic               alu_carry, alu_err;

  logic               div_go;
  logic               res_we;
  logic [2*WIDTH-1:0] res_s;
  logic               res_c, res_e;

  function automatic logic [2*WIDTH-1:0] ext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  assign sum = {1'b0, a_reg} + {1'b0, b_reg};

  // Single-cycle result from the captured operands.
  always_comb begin
    alu_s     = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_s     = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_s     = ext(a_reg) - ext(b_reg);
        alu_carry = (a_reg < b_reg);
      end
      OP_MUL:  alu_s = ext(a_reg) * ext(b_reg);
      OP_DIV: begin
`ifdef ULA_DIV_EN
        // Only reached for B=0; non-zero divisors go through the DIV state.
        alu_s   = {a_reg, {WIDTH{1'b1}}};
        alu_err = 1'b1;
`else
        alu_s   = '0;
        alu_err = 1'b1;
`endif
      end
      OP_SHL:  alu_s = ext(a_reg << 1);
      OP_SHR:  alu_s = ext(a_reg >> 1);
      OP_ROL:  alu_s = ext({a_reg[WIDTH-2:0], a_reg[WIDTH-1]});
      OP_ROR:  alu_s = ext({a_reg[0], a_reg[WIDTH-1:1]});
      OP_AND:  alu_s = ext(a_reg & b_reg);
      OP_OR:   alu_s = ext(a_reg | b_reg);
      OP_XOR:  alu_s = ext(a_reg ^ b_reg);
      OP_NOR:  alu_s = ext(~(a_reg | b_reg));
      OP_NAND: alu_s = ext(~(a_reg & b_reg));
      OP_XNOR: alu_s = ext(~(a_reg ^ b_reg));
      OP_GT:   alu_s = {{(2*WIDTH-1){1'b0}}, (a_reg > b_reg)};
      OP_EQ:   alu_s = {{(2*WIDTH-1){1'b0}}, (a_reg == b_reg)};
      default: alu_s = '0;
    endcase
  end

`ifdef ULA_DIV_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_reg, quo_reg, rem_next, quo_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   trial, diff;
  logic             div_last;

  assign div_go   = (op_reg == OP_DIV) && (b_reg != '0);
  assign div_last = (cnt_reg == CW'(WIDTH - 1));

  // Restoring step: the quotient register shifts its MSB into the partial
  // remainder. Because rem < B, the trial value is below 2B, so the borrow
  // bit diff[WIDTH] alone says whether the subtraction must be undone.
  always_comb begin
    trial    = {rem_reg, quo_reg[WIDTH-1]};
    diff     = trial - {1'b0, b_reg};
    rem_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_reg <= '0;
      quo_reg <= '0;
      cnt_reg <= '0;
    end else if (state_reg == ST_CALC) begin
      rem_reg <= '0;
      quo_reg <= a_reg;
      cnt_reg <= '0;
    end else if (state_reg == ST_DIV) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign div_go = 1'b0;
`endif

  // Result write-back: either the single-cycle ALU value leaving CALC or the
  // final divider step leaving DIV.
  always_comb begin
    res_we = 1'b0;
    res_s  = alu_s;
    res_c  = alu_carry;
    res_e  = alu_err;
    if (state_reg == ST_CALC && !div_go) begin
      res_we = 1'b1;
    end
`ifdef ULA_DIV_EN
    if (state_reg == ST_DIV && div_last) begin
      res_we = 1'b1;
      res_s  = {rem_next, quo_next};
      res_c  = 1'b0;
      res_e  = 1'b0;
    end
`endif
  end

  // FSM next state and outputs.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        busy       = 1'b1;
        state_next = ST_DONE;
`ifdef ULA_DIV_EN
        if (div_go) state_next = ST_DIV;
`endif
      end
`ifdef ULA_DIV_EN
      ST_DIV: begin
        busy = 1'b1;
        if (div_last) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= Seletor;
        a_reg  <= A;
        b_reg  <= B;
      end
      if (res_we) begin
        s_reg     <= res_s;
        zero_reg  <= (res_s == '0);
        carry_reg <= res_c;
        err_reg   <= res_e;
      end
    end
  end

  assign S     = s_reg;
  assign zero  = zero_reg;
  assign carry = carry_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;

  localparam int W = 8;
`ifdef ULA_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam longint M  = (longint'(1) << W) - 1;
  localparam longint M2 = (longint'(1) << (2*W)) - 1;

  logic           clock   = 1'b0;
  logic           reset_n = 1'b1;
  logic           start   = 1'b0;
  logic [3:0]     Seletor = 4'd0;
  logic [W-1:0]   A       = '0;
  logic [W-1:0]   B       = '0;
  logic           busy, done, zero, carry, err;
  logic [2*W-1:0] S;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  int             lat;
  bit             bok, got, nd;
  logic [3:0]     op37;
  logic [15:0]    exp37;
  int             rst_delay;

  ula_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .Seletor (Seletor),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .S       (S),
    .zero    (zero),
    .carry   (carry),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference result from the operation definitions: returns {carry, err, S}.
  function automatic logic [2*W+1:0] ref_op(input logic [3:0] op,
                                            input logic [W-1:0] a_in,
                                            input logic [W-1:0] b_in);
    longint a, b, s;
    logic c, e;
    a = longint'(a_in);
    b = longint'(b_in);
    s = 0; c = 1'b0; e = 1'b0;
    case (op)
      4'd0: begin s = a + b; c = (s > M); end
      4'd1: begin s = (a - b) & M2; c = (a < b); end
      4'd2: s = a * b;
      4'd3: begin
        if (!DIV_EN)     begin s = 0; e = 1'b1; end
        else if (b == 0) begin s = (a << W) | M; e = 1'b1; end
        else             s = ((a % b) << W) | (a / b);
      end
      4'd4:  s = (a << 1) & M;
      4'd5:  s = a >> 1;
      4'd6:  s = ((a << 1) & M) | (a >> (W-1));
      4'd7:  s = (a >> 1) | ((a & 1) << (W-1));
      4'd8:  s = a & b;
      4'd9:  s = a | b;
      4'd10: s = a ^ b;
      4'd11: s = ~(a | b) & M;
      4'd12: s = ~(a & b) & M;
      4'd13: s = ~(a ^ b) & M;
      4'd14: s = (a > b) ? 1 : 0;
      default: s = (a == b) ? 1 : 0;
    endcase
    return {c, e, s[2*W-1:0]};
  endfunction

  // Behavioural model: an accepted request stays busy for its latency in
  // cycles, then done is shown for one cycle with the reference result, then
  // one idle cycle before the next request can be taken.
  int               m_left = 0;
  bit               m_done = 1'b0;
  logic [2*W+1:0]   m_res  = '0;
  logic [2*W-1:0]   m_s    = '0;
  bit               m_z = 1'b0, m_c = 1'b0, m_e = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0; m_done <= 1'b0; m_res <= '0;
      m_s <= '0; m_z <= 1'b0; m_c <= 1'b0; m_e <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_s    <= m_res[2*W-1:0];
        m_z    <= (m_res[2*W-1:0] == '0);
        m_c    <= m_res[2*W+1];
        m_e    <= m_res[2*W];
      end
    end else if (start) begin
      m_res  <= ref_op(Seletor, A, B);
      m_left <= (DIV_EN && Seletor == 4'd3 && B != '0) ? W + 1 : 1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp_busy",  longint'(busy),  longint'(m_left > 0));
      chk("cmp_done",  longint'(done),  longint'(m_done));
      chk("cmp_S",     longint'(S),     longint'(m_s));
      chk("cmp_zero",  longint'(zero),  longint'(m_z));
      chk("cmp_carry", longint'(carry), longint'(m_c));
      chk("cmp_err",   longint'(err),   longint'(m_e));
    end
  end

  // Issues one request and returns at the falling edge of the done cycle.
  // l = edges from acceptance until done rose (-1 if it never did).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int l, output bit b_ok);
    @(posedge clock); #1;
    start = 1'b1; Seletor = op; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0;
    l = -1; b_ok = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (done) begin l = i - 1; break; end
      if (!busy) b_ok = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2 reset_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_S",     S,     0);
    chk("rst_zero",  zero,  0);
    chk("rst_carry", carry, 0);
    chk("rst_err",   err,   0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    run_op(4'd0, 8'd200, 8'd100, lat, bok);
    chk("add_lat", lat, 1);
    chk("add_S", S, 300);
    chk("add_carry", carry, 1);
    chk("add_zero", zero, 0);

    run_op(4'd1, 8'd5, 8'd7, lat, bok);
    chk("sub_S", S, 16'hFFFE);
    chk("sub_carry", carry, 1);

    run_op(4'd2, 8'd255, 8'd255, lat, bok);
    chk("mul_S", S, 16'hFE01);
    chk("mul_carry", carry, 0);

    run_op(4'd10, 8'h5A, 8'h5A, lat, bok);
    chk("xor_S", S, 0);
    chk("xor_zero", zero, 1);

    run_op(4'd3, 8'd200, 8'd7, lat, bok);
    chk("div_lat", lat, DIV_EN ? 9 : 1);
    chk("div_S", S, DIV_EN ? 16'h041C : 16'h0000);
    chk("div_busy", bok, 1);
    chk("div_err", err, DIV_EN ? 0 : 1);

    run_op(4'd3, 8'd9, 8'd0, lat, bok);
    chk("div0_lat", lat, 1);
    chk("div0_S", S, DIV_EN ? 16'h09FF : 16'h0000);
    chk("div0_err", err, 1);

    run_op(4'd14, 8'd3, 8'd2, lat, bok);
    chk("gt_S", S, 1);

    // Abort an operation in flight with an asynchronous reset pulse.
    rst_delay = DIV_EN ? 4 : 0;
    @(posedge clock); #1;
    start = 1'b1; Seletor = DIV_EN ? 4'd3 : 4'd2; A = 8'd200; B = 8'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (rst_delay) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy",  busy,  0);
    chk("abort_done",  done,  0);
    chk("abort_S",     S,     0);
    chk("abort_zero",  zero,  0);
    chk("abort_carry", carry, 0);
    chk("abort_err",   err,   0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    nd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) nd = 1'b0;
    end
    chk("abort_no_done", nd, 1);

    run_op(4'd6, 8'h81, 8'h00, lat, bok);
    chk("rol_lat", lat, 1);
    chk("rol_S", S, 16'h0003);

    // start held high; operands change while the operation runs.
    op37  = DIV_EN ? 4'd3 : 4'd2;
    exp37 = DIV_EN ? 16'h041C : 16'h0578;
    @(posedge clock); #1;
    start = 1'b1; Seletor = op37; A = 8'd200; B = 8'd7;
    @(posedge clock); #1;
    A = 8'd13; B = 8'd3;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; break; end
    end
    chk("hold_done_seen", got, 1);
    chk("hold_S", S, exp37);
    @(negedge clock);
    chk("hold_gap_busy", busy, 0);
    @(negedge clock);
    chk("hold_reaccept_busy", busy, 1);
    start = 1'b0;
    repeat (20) @(negedge clock);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      start   = ($urandom_range(0, 2) != 0);
      Seletor = 4'($urandom_range(0, 15));
      A       = W'($urandom);
      B       = W'($urandom);
      case ($urandom_range(0, 7))
        0: B = '0;
        1: B = A;
        default: ;
      endcase
    end
    @(posedge clock); #1;
    start = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
